// File: rtl/dff_reg_arbiter_if.sv
// dff_reg_arbiter_if: request/grant/data bundle shared between requesters and the arbiter
interface dff_reg_arbiter_if #(
    parameter int N     = 4,
    parameter int WIDTH = 8
);
    logic [N-1:0]       req;
    logic [N*WIDTH-1:0] wdata;
    logic [N-1:0]       gnt;
    logic [N-1:0]       ack;
    logic [WIDTH-1:0]   q;
    logic [WIDTH-1:0]   qb;
    logic               busy;
    modport master (output req, wdata, input gnt, ack, q, qb, busy);
    modport slave  (input req, wdata, output gnt, ack, q, qb, busy);
endinterface

// File: rtl/dff_reg_arbiter.sv
// dff_reg_arbiter: round-robin arbiter loading one requester's value into a shared register
module dff_reg_arbiter #(
    parameter int N     = 4,
    parameter int WIDTH = 8
) (
    input logic             clk,
    input logic             reset,
    dff_reg_arbiter_if.slave bus
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;
    typedef enum logic [1:0] {IDLE, GRANT, ACK} state_t;
    state_t           r_state, w_state_nxt;
    logic [PW-1:0]    r_ptr, w_ptr_nxt, r_w, w_w_nxt, w_win;
    logic [N-1:0]     r_gnt, w_gnt_nxt, r_ack, w_ack_nxt;
    logic [WIDTH-1:0] r_q, w_q_nxt;
    logic [WIDTH-1:0] w_slice [N];
    // First set bit at or above p, wrapping; lowest offset from p wins.
    function automatic logic [PW-1:0] f_pick(input logic [N-1:0] rq, input logic [PW-1:0] p);
        logic [PW-1:0] w;
        logic [PW-1:0] j;
        w = p;
        for (int k = N - 1; k >= 0; k--) begin
            j = PW'((int'(p) + k) % N);
            if (rq[j]) w = j;
        end
        return w;
    endfunction
    for (genvar i = 0; i < N; i++) begin : g_slice
        assign w_slice[i] = bus.wdata[i*WIDTH +: WIDTH];
    end
    assign w_win = f_pick(bus.req, r_ptr);
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_w     <= '0;
            r_gnt   <= '0;
            r_ack   <= '0;
            r_q     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_w     <= w_w_nxt;
            r_gnt   <= w_gnt_nxt;
            r_ack   <= w_ack_nxt;
            r_q     <= w_q_nxt;
        end
    end
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_w_nxt     = r_w;
        w_gnt_nxt   = '0;
        w_ack_nxt   = '0;
        w_q_nxt     = r_q;
        case (r_state)
            IDLE: if (|bus.req) begin
                w_w_nxt     = w_win;
                w_gnt_nxt   = N'(1) << w_win;
                w_state_nxt = GRANT;
            end
            GRANT: begin
                w_state_nxt = bus.req[r_w] ? ACK : IDLE;
                if (bus.req[r_w]) begin
                    w_q_nxt   = w_slice[r_w];
                    w_ack_nxt = N'(1) << r_w;
                end
            end
            ACK: begin
                w_ptr_nxt   = (r_w == PW'(N - 1)) ? '0 : r_w + 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end
    assign bus.gnt  = r_gnt;
    assign bus.ack  = r_ack;
    assign bus.q    = r_q;
    assign bus.qb   = ~r_q;
    assign bus.busy = (r_state != IDLE);
endmodule

// File: tb/tb_dff_reg_arbiter.sv
// tb_dff_reg_arbiter: directed scenarios plus randomized traffic against a transaction-level model
module tb_dff_reg_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;
    dff_reg_arbiter_if #(.N(4), .WIDTH(8)) bus4 ();
    dff_reg_arbiter_if #(.N(3), .WIDTH(8)) bus3 ();
    dff_reg_arbiter #(.N(4), .WIDTH(8)) dut4 (.clk(clk), .reset(reset), .bus(bus4));
    dff_reg_arbiter #(.N(3), .WIDTH(8)) dut3 (.clk(clk), .reset(reset), .bus(bus3));
    always #5 clk = ~clk;
    // Reference: a transaction is "granted" one cycle after it is chosen and "acknowledged" the next.
    int         m_phase = 0;
    int         m_w = 0;
    int         m_ptr = 0;
    logic [7:0] m_q = '0;
    always @(posedge clk) begin
        logic [3:0] r;
        r = bus4.req;
        if (reset) begin
            m_phase = 0;
            m_ptr   = 0;
            m_q     = '0;
        end else if (m_phase == 1 && r[2'(m_w)]) begin
            m_q     = 8'(bus4.wdata >> (8 * m_w));
            m_phase = 2;
        end else if (m_phase == 2) begin
            m_ptr   = (m_w + 1) % 4;
            m_phase = 0;
        end else if (m_phase == 1) begin
            m_phase = 0;
        end else if (r != 0) begin
            for (int k = 3; k >= 0; k--)
                if (r[2'((m_ptr + k) % 4)]) m_w = (m_ptr + k) % 4;
            m_phase = 1;
        end
    end
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic test_reset;
        reset = 1'b1;
        bus4.req = 4'b1111;
        bus4.wdata = $urandom;
        tick();
        tick();
        n_checks += 5;
        if (bus4.q !== 8'h00) begin n_fail++; $display("FAIL reset_q: got %h exp 00", bus4.q); end
        if (bus4.qb !== 8'hFF) begin n_fail++; $display("FAIL reset_qb: got %h exp ff", bus4.qb); end
        if (bus4.gnt !== 4'b0) begin n_fail++; $display("FAIL reset_gnt: got %b exp 0000", bus4.gnt); end
        if (bus4.ack !== 4'b0) begin n_fail++; $display("FAIL reset_ack: got %b exp 0000", bus4.ack); end
        if (bus4.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b exp 0", bus4.busy); end
        reset = 1'b0;
        bus4.req = '0;
        tick();
        n_checks += 2;
        if (dut4.r_ptr !== 2'd0) begin n_fail++; $display("FAIL reset_ptr: got %0d exp 0", dut4.r_ptr); end
        if (bus4.busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle_busy: got %b exp 0", bus4.busy); end
    endtask
    task automatic test_single_write;
        bus4.wdata = $urandom;
        bus4.wdata[23:16] = 8'hA5;
        bus4.req = 4'b0100;
        tick();
        n_checks += 3;
        if (bus4.gnt !== 4'b0100) begin n_fail++; $display("FAIL single_gnt: got %b exp 0100", bus4.gnt); end
        if (bus4.ack !== 4'b0) begin n_fail++; $display("FAIL single_ack_early: got %b exp 0000", bus4.ack); end
        if (bus4.busy !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %b exp 1", bus4.busy); end
        tick();
        n_checks += 4;
        if (bus4.q !== 8'hA5) begin n_fail++; $display("FAIL single_q: got %h exp a5", bus4.q); end
        if (bus4.qb !== 8'h5A) begin n_fail++; $display("FAIL single_qb: got %h exp 5a", bus4.qb); end
        if (bus4.ack !== 4'b0100) begin n_fail++; $display("FAIL single_ack: got %b exp 0100", bus4.ack); end
        if (bus4.gnt !== 4'b0) begin n_fail++; $display("FAIL single_gnt_drop: got %b exp 0000", bus4.gnt); end
        bus4.req = '0;
        tick();
        n_checks += 2;
        if (bus4.busy !== 1'b0) begin n_fail++; $display("FAIL single_done_busy: got %b exp 0", bus4.busy); end
        if (bus4.ack !== 4'b0) begin n_fail++; $display("FAIL single_ack_pulse: got %b exp 0000", bus4.ack); end
    endtask
    task automatic test_round_robin;
        logic [3:0] e_oh;
        logic [7:0] e_q;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus4.wdata = 32'h13121110;
        bus4.req = 4'hF;
        for (int i = 0; i < 5; i++) begin
            e_oh = 4'(1 << (i % 4));
            e_q = 8'h10 + 8'(i % 4);
            tick();
            n_checks++;
            if (bus4.gnt !== e_oh) begin n_fail++; $display("FAIL rr_gnt[%0d]: got %b exp %b", i, bus4.gnt, e_oh); end
            tick();
            n_checks += 2;
            if (bus4.ack !== e_oh) begin n_fail++; $display("FAIL rr_ack[%0d]: got %b exp %b", i, bus4.ack, e_oh); end
            if (bus4.q !== e_q) begin n_fail++; $display("FAIL rr_q[%0d]: got %h exp %h", i, bus4.q, e_q); end
            tick();
            n_checks++;
            if (bus4.busy !== 1'b0) begin n_fail++; $display("FAIL rr_idle[%0d]: got busy %b exp 0", i, bus4.busy); end
        end
        bus4.req = '0;
        tick();
    endtask
    task automatic test_withdrawal;
        logic [7:0] d;
        d = 8'($urandom);
        bus4.wdata[15:8] = d;
        bus4.req = 4'b0010;
        tick();
        n_checks++;
        if (bus4.gnt !== 4'b0010) begin n_fail++; $display("FAIL wd_gnt: got %b exp 0010", bus4.gnt); end
        bus4.req = '0;
        tick();
        n_checks += 4;
        if (bus4.ack !== 4'b0) begin n_fail++; $display("FAIL wd_ack: got %b exp 0000", bus4.ack); end
        if (bus4.gnt !== 4'b0) begin n_fail++; $display("FAIL wd_gnt_drop: got %b exp 0000", bus4.gnt); end
        if (bus4.busy !== 1'b0) begin n_fail++; $display("FAIL wd_busy: got %b exp 0", bus4.busy); end
        if (bus4.q !== 8'h10) begin n_fail++; $display("FAIL wd_q_hold: got %h exp 10", bus4.q); end
        bus4.req = 4'b0011;
        tick();
        n_checks++;
        if (bus4.gnt !== 4'b0010) begin n_fail++; $display("FAIL wd_regnt: got %b exp 0010", bus4.gnt); end
        tick();
        n_checks += 2;
        if (bus4.ack !== 4'b0010) begin n_fail++; $display("FAIL wd_reack: got %b exp 0010", bus4.ack); end
        if (bus4.q !== d) begin n_fail++; $display("FAIL wd_req_q: got %h exp %h", bus4.q, d); end
        bus4.req = '0;
        tick();
    endtask
    task automatic test_reset_mid;
        logic [7:0] d;
        d = 8'($urandom);
        bus4.wdata[31:24] = 8'hC3;
        bus4.wdata[7:0] = d;
        bus4.req = 4'b1000;
        tick();
        n_checks++;
        if (bus4.gnt !== 4'b1000) begin n_fail++; $display("FAIL rm_gnt: got %b exp 1000", bus4.gnt); end
        reset = 1'b1;
        tick();
        n_checks += 4;
        if (bus4.q !== 8'h00) begin n_fail++; $display("FAIL rm_q: got %h exp 00", bus4.q); end
        if (bus4.gnt !== 4'b0) begin n_fail++; $display("FAIL rm_gnt_clr: got %b exp 0000", bus4.gnt); end
        if (bus4.ack !== 4'b0) begin n_fail++; $display("FAIL rm_ack: got %b exp 0000", bus4.ack); end
        if (bus4.busy !== 1'b0) begin n_fail++; $display("FAIL rm_busy: got %b exp 0", bus4.busy); end
        reset = 1'b0;
        bus4.req = 4'b1001;
        tick();
        n_checks += 2;
        if (bus4.gnt !== 4'b0001) begin n_fail++; $display("FAIL rm_next_gnt: got %b exp 0001", bus4.gnt); end
        if (bus4.ack !== 4'b0) begin n_fail++; $display("FAIL rm_no_ack: got %b exp 0000", bus4.ack); end
        tick();
        n_checks += 2;
        if (bus4.ack !== 4'b0001) begin n_fail++; $display("FAIL rm_next_ack: got %b exp 0001", bus4.ack); end
        if (bus4.q !== d) begin n_fail++; $display("FAIL rm_next_q: got %h exp %h", bus4.q, d); end
        bus4.req = '0;
        tick();
    endtask
    task automatic test_npot;
        logic [2:0] e_oh;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus3.wdata = 24'($urandom);
        bus3.req = 3'b111;
        for (int i = 0; i < 5; i++) begin
            e_oh = 3'(1 << (i % 3));
            tick();
            n_checks += 2;
            if (bus3.gnt !== e_oh) begin n_fail++; $display("FAIL npot_gnt[%0d]: got %b exp %b", i, bus3.gnt, e_oh); end
            if (dut3.r_ptr == 2'd3) begin n_fail++; $display("FAIL npot_ptr_g[%0d]: got 3 exp <3", i); end
            tick();
            n_checks += 2;
            if (bus3.ack !== e_oh) begin n_fail++; $display("FAIL npot_ack[%0d]: got %b exp %b", i, bus3.ack, e_oh); end
            if (dut3.r_ptr == 2'd3) begin n_fail++; $display("FAIL npot_ptr_a[%0d]: got 3 exp <3", i); end
            tick();
            n_checks++;
            if (dut3.r_ptr == 2'd3) begin n_fail++; $display("FAIL npot_ptr_i[%0d]: got 3 exp <3", i); end
        end
        bus3.req = '0;
        tick();
    endtask
    task automatic test_random;
        logic [3:0] e_gnt, e_ack;
        for (int c = 0; c < 400; c++) begin
            bus4.req = ($urandom_range(0, 3) == 0) ? 4'b0 : 4'($urandom);
            bus4.wdata = $urandom;
            if ($urandom_range(0, 99) == 0) reset = 1'b1;
            tick();
            reset = 1'b0;
            e_gnt = (m_phase == 1) ? 4'(1 << m_w) : 4'b0;
            e_ack = (m_phase == 2) ? 4'(1 << m_w) : 4'b0;
            n_checks += 6;
            if (bus4.gnt !== e_gnt) begin n_fail++; $display("FAIL rnd_gnt@%0d: got %b exp %b", c, bus4.gnt, e_gnt); end
            if (bus4.ack !== e_ack) begin n_fail++; $display("FAIL rnd_ack@%0d: got %b exp %b", c, bus4.ack, e_ack); end
            if (bus4.q !== m_q) begin n_fail++; $display("FAIL rnd_q@%0d: got %h exp %h", c, bus4.q, m_q); end
            if (bus4.qb !== ~m_q) begin n_fail++; $display("FAIL rnd_qb@%0d: got %h exp %h", c, bus4.qb, ~m_q); end
            if (bus4.busy !== (m_phase != 0)) begin n_fail++; $display("FAIL rnd_busy@%0d: got %b exp %b", c, bus4.busy, m_phase != 0); end
            if ((bus4.gnt != 0 && bus4.ack != 0) || !$onehot0(bus4.gnt) || !$onehot0(bus4.ack)) begin
                n_fail++;
                $display("FAIL rnd_onehot@%0d: got gnt %b ack %b exp exclusive one-hot", c, bus4.gnt, bus4.ack);
            end
        end
        bus4.req = '0;
        tick();
    endtask
    initial begin
        bus4.req = '0;
        bus4.wdata = '0;
        bus3.req = '0;
        bus3.wdata = '0;
        test_reset();
        test_single_write();
        test_round_robin();
        test_withdrawal();
        test_reset_mid();
        test_npot();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/dff_reg_arbiter.md
Name: dff_reg_arbiter

Overview:
- Round-robin arbiter and sequencer sharing one WIDTH-bit flip-flop register among N requesters.
- Each requester presents a write value under a req/ack handshake.
- The block grants one requester at a time, loads its value into the shared register and acknowledges it.
- Exposes q and its complement qb to downstream logic.

Parameters:
N, 4, number of requesters (2..8)
WIDTH, 8, width of shared register and each write value

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
req  input  N  per-requester write request, level, bit i = requester i
wdata  input  N*WIDTH  write values, requester i at bits [i*WIDTH +: WIDTH]
gnt  output  N  one-hot grant, registered
ack  output  N  one-hot write acknowledge, 1-cycle pulse, registered
q  output  WIDTH  shared register contents
qb  output  WIDTH  bitwise complement of q (combinational)
busy  output  1  high whenever FSM is not IDLE

Behaviour:
- Reset is synchronous, active-high, clock clk. On reset at any rising edge, in any state:
  - q=0, qb=all ones, gnt=0, ack=0, busy=0.
  - state=IDLE, round-robin pointer ptr=0.
  - Reset mid-transaction aborts it with no write and no ack.
- FSM states: IDLE, GRANT, ACK.
- IDLE:
  - If req!=0, select winner w = first set bit of req searching from index ptr upward, wrapping N-1 -> 0.
  - Register gnt = onehot(w), store w internally, go to GRANT.
  - If req==0, stay in IDLE with gnt=0.
- GRANT (one cycle, gnt held):
  - If req[w]==1: q <= wdata slice w at the end of this cycle, go to ACK.
  - If req[w]==0 (requester withdrew): no write, gnt <= 0, ptr unchanged, return to IDLE.
- ACK (one cycle):
  - ack = onehot(w), gnt deasserted in this cycle.
  - ptr <= (w+1) mod N; go to IDLE.
- Latency: req rising seen in cycle 0 -> gnt high in cycle 1 -> q updated and ack high in cycle 2 -> IDLE in cycle 3.
  - Minimum spacing between two writes is 3 cycles.
- Requester obligation: hold req and wdata stable until ack, then drop req.
  - A req still high in the IDLE cycle after its ack is a new request.
  - It is arbitrated at the lowest priority because ptr has moved past it.
- Fairness: with all N requesting continuously, grants rotate 0,1,..,N-1,0; no requester waits more than N transactions.
- wdata of non-granted requesters is ignored. q holds its value between writes.
- gnt and ack are never both nonzero in the same cycle; each is at most one-hot.
- busy = (state != IDLE).
- ptr width = ceil(log2 N). Wrap-around is explicit for non-power-of-two N.

Test Plan:
- Reset: assert reset 2 cycles with req=4'b1111 -> q=8'h00, qb=8'hFF, gnt=0, ack=0, busy=0; ptr=0 after release.
- Single write: req=4'b0100, wdata[23:16]=8'hA5 in cycle 0 -> gnt=4'b0100 in cycle 1; q=8'hA5, qb=8'h5A, ack=4'b0100 in cycle 2; busy low in cycle 3.
- Round-robin: req=4'b1111 held, wdata = 8'h10,8'h11,8'h12,8'h13 for requesters 0..3 -> ack sequence 0,1,2,3,0 every 3 cycles; q tracks 10,11,12,13,10.
- Withdrawal: req=4'b0010, drop req in the GRANT cycle -> no ack, q unchanged; then req=4'b0011 -> requester 1 granted first, since ptr is still at 1.
- Reset mid-operation: reset asserted in the GRANT cycle for requester 3 with wdata 8'hC3 -> q=0, no ack ever issued; next request from 0 granted first.
- Non-power-of-two: N=3, req=3'b111 continuous -> grants 0,1,2,0,1; ptr never takes value 3.
